// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M op encodings, FSM state type and op decode helpers
// shared by the iterative multiply/divide unit.
`default_nettype none

package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed1(input logic [2:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed2(input logic [2:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_high(input logic [2:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, radix-2 shift-add multiply and
// restoring divide over XLEN cycles with a start/ready handshake. Rev 1.0
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_sh;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_data;
  logic [2:0]        r_op;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_ready, w_accept;
  logic              w_neg1, w_neg2;
  logic [XLEN-1:0]   w_mag1, w_mag2;
  logic              w_div0, w_ovf, w_special;
  logic [XLEN-1:0]   w_special_res;

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept = start_i && w_ready && !flush_i;

  // Operand signs and magnitudes; -MIN wraps to 2^(XLEN-1), the correct magnitude.
  assign w_neg1 = is_signed1(op_i) && data1_i[XLEN-1];
  assign w_neg2 = is_signed2(op_i) && data2_i[XLEN-1];
  assign w_mag1 = w_neg1 ? -data1_i : data1_i;
  assign w_mag2 = w_neg2 ? -data2_i : data2_i;

  assign w_div0    = is_div(op_i) && (data2_i == '0);
  assign w_ovf     = is_div(op_i) && is_signed1(op_i) &&
                     (data1_i == MIN_VAL) && (data2_i == '1);
  assign w_special = w_div0 || w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div0)
      w_special_res = op_i[1] ? data1_i : '1;
    else if (w_ovf)
      w_special_res = op_i[1] ? '0 : MIN_VAL;
  end

  // One iteration of either datapath; both share r_acc (high/remainder) and r_sh.
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_trial;
  logic              w_qbit;
  logic [XLEN-1:0]   w_acc_nxt, w_sh_nxt;

  assign w_mul_sum   = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_b} : '0);
  assign w_div_shift = {r_acc, r_sh[XLEN-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_b};
  assign w_qbit      = !w_div_trial[XLEN];

  always_comb begin
    w_acc_nxt = r_acc;
    w_sh_nxt  = r_sh;
    if (is_div(r_op)) begin
      w_acc_nxt = w_qbit ? w_div_trial[XLEN-1:0] : w_div_shift[XLEN-1:0];
      w_sh_nxt  = {r_sh[XLEN-2:0], w_qbit};
    end else begin
      w_acc_nxt = w_mul_sum[XLEN:1];
      w_sh_nxt  = {w_mul_sum[0], r_sh[XLEN-1:1]};
    end
  end

  // Sign fix-up applied to the final iteration's values.
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0]   w_quo, w_rem, w_result;

  assign w_prod     = {w_acc_nxt, w_sh_nxt};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo      = r_neg_q ? -w_sh_nxt : w_sh_nxt;
  assign w_rem      = r_neg_r ? -w_acc_nxt : w_acc_nxt;

  always_comb begin
    w_result = w_prod_fix[XLEN-1:0];
    if (is_div(r_op))
      w_result = r_op[1] ? w_rem : w_quo;
    else if (is_high(r_op))
      w_result = w_prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept)
            w_state_nxt = w_special ? ST_DONE : ST_BUSY;
          else
            w_state_nxt = ST_IDLE;
        end
        ST_BUSY: begin
          if (r_cnt == '0)
            w_state_nxt = ST_DONE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc   <= '0;
      r_sh    <= '0;
      r_b     <= '0;
      r_data  <= '0;
      r_op    <= OP_MUL;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
    end else if (!flush_i) begin
      if (w_accept) begin
        r_op    <= op_i;
        r_neg_q <= w_neg1 ^ w_neg2;
        r_neg_r <= w_neg1;
        r_acc   <= '0;
        r_sh    <= w_mag1;
        r_b     <= w_mag2;
        r_cnt   <= CNT_W'(XLEN - 1);
        if (w_special)
          r_data <= w_special_res;
      end else if (r_state == ST_BUSY) begin
        r_acc <= w_acc_nxt;
        r_sh  <= w_sh_nxt;
        if (r_cnt == '0)
          r_data <= w_result;
        else
          r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign ready_o = w_ready;
  assign busy_o  = (r_state == ST_BUSY);
  assign valid_o = (r_state == ST_DONE);
  assign data_o  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model.
`default_nettype none

module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic        ready, busy, valid;
  logic [31:0] dout;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .data1_i (d1),
    .data2_i (d2),
    .flush_i (flush),
    .ready_o (ready),
    .busy_o  (busy),
    .valid_o (valid),
    .data_o  (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    logic [63:0] p;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_res;
    int exp_lat;
    int edges;
    exp_res = ref_res(o, a, b);
    exp_lat = is_special(o, a, b) ? 1 : XLEN + 1;
    @(negedge clk);
    op = o; d1 = a; d2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); d1 = $urandom; d2 = $urandom;
    edges = 1;
    while (!valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check($sformatf("latency op%0d %h,%h", o, a, b), 32'(edges), 32'(exp_lat));
    check($sformatf("result op%0d %h,%h", o, a, b), dout, exp_res);
    @(posedge clk); #1;
    check("valid one-cycle pulse", {31'd0, valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    int nvalid, e, e1, e2;
    logic [31:0] r1, r2;
    logic ready_in_done;

    repeat (2) @(negedge clk);
    check("reset ready", {31'd0, ready}, 32'd1);
    check("reset busy",  {31'd0, busy},  32'd0);
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset data",  dout, 32'd0);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd7, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 32; i++)
      run_op(3'($urandom), pick(), pick());

    // Flush mid-divide: no result, data held, back to idle.
    prev = dout;
    @(negedge clk);
    op = 3'd4; d1 = 32'd1000; d2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush ready", {31'd0, ready}, 32'd1);
    check("flush busy",  {31'd0, busy},  32'd0);
    check("flush valid", {31'd0, valid}, 32'd0);
    check("flush data held", dout, prev);
    @(negedge clk);
    op = 3'd0; d1 = 32'd9; d2 = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start under flush ignored", {30'd0, busy, valid}, 32'd0);
    nvalid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    check("no valid after flush", 32'(nvalid), 32'd0);
    check("data held after flush", dout, prev);

    // Asynchronous reset mid-multiply.
    @(negedge clk);
    op = 3'd0; d1 = 32'h1234; d2 = 32'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid reset ready", {31'd0, ready}, 32'd1);
    check("mid reset busy",  {31'd0, busy},  32'd0);
    check("mid reset valid", {31'd0, valid}, 32'd0);
    check("mid reset data",  dout, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd0, 32'd11, 32'd13);

    // Back-to-back with start held high.
    @(negedge clk);
    op = 3'd0; d1 = 32'd3; d2 = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    d1 = 32'd5; d2 = 32'd6;
    e = 1; nvalid = 0; e1 = 0; e2 = 0; r1 = '0; r2 = '0; ready_in_done = 1'b1;
    while (nvalid < 2 && e < 120) begin
      @(posedge clk); #1;
      e++;
      if (valid) begin
        if (!ready) ready_in_done = 1'b0;
        if (nvalid == 0) begin e1 = e; r1 = dout; end
        else begin e2 = e; r2 = dout; start = 1'b0; end
        nvalid++;
      end
    end
    start = 1'b0;
    check("b2b first latency", 32'(e1), 32'd33);
    check("b2b spacing", 32'(e2 - e1), 32'd33);
    check("b2b first result", r1, 32'd12);
    check("b2b second result", r2, 32'd30);
    check("b2b ready in done", {31'd0, ready_in_done}, 32'd1);
    @(posedge clk); #1;
    check("b2b idle after", {30'd0, busy, valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
